// File: rtl/display_sched_pkg.sv
`default_nettype none
// ============================================================================
//  display_sched_pkg
//  Shared scheduler state type and one-hot helper for the display scheduler.
//  Revision: 1.0
// ============================================================================
package display_sched_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHOW  = 2'd2
    } sched_state_t;

    // Callers truncate the result to their own source count.
    function automatic logic [MAX_SRC-1:0] onehot(input logic [31:0] sel);
        onehot = MAX_SRC'(1) << sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_next_sel.sv
`default_nettype none
// ============================================================================
//  rr_next_sel
//  Combinational round-robin picker: first set request after ptr, wrapping.
//  Revision: 1.0
// ============================================================================
module rr_next_sel #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [SEL_W-1:0]   ptr_i,
    output logic               found_o,
    output logic [SEL_W-1:0]   sel_o
);

    localparam int IW = SEL_W + 1;

    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found_o = 1'b0;
        sel_o   = '0;
        idx     = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = IW'(ptr_i) + IW'(k);
            if (idx >= IW'(NUM_SRC)) begin
                idx = idx - IW'(NUM_SRC);
            end
            if (req_i[idx[SEL_W-1:0]]) begin
                found_o = 1'b1;
                sel_o   = idx[SEL_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_source_scheduler.sv
`default_nettype none
// ============================================================================
//  display_source_scheduler
//  Round-robin time-sharing of the seven-segment display and LEDs.
//  Revision: 1.0
// ============================================================================
module display_source_scheduler
    import display_sched_pkg::*;
#(
    parameter  int NUM_SRC      = 4,
    parameter  int DATA_W       = 16,
    parameter  int DWELL_CYCLES = 100_000_000,
    localparam int SEL_W        = $clog2(NUM_SRC),
    localparam int CNT_W        = $clog2(DWELL_CYCLES)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_SRC*DATA_W-1:0] src_value_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    input  logic                      hold_i,
    input  logic                      step_i,
    output logic [DATA_W-1:0]         disp_value_o,
    output logic [SEL_W-1:0]          disp_src_o,
    output logic                      disp_valid_o,
    output logic                      slot_start_o,
    output logic [NUM_SRC-1:0]        src_ack_o
);

    sched_state_t         state_q;
    logic [SEL_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [DATA_W-1:0]    disp_value_q;
    logic [SEL_W-1:0]     disp_src_q;
    logic                 disp_valid_q;
    logic                 slot_start_q;
    logic [NUM_SRC-1:0]   src_ack_q;

    logic [DATA_W-1:0]    src_arr [NUM_SRC];
    logic                 pick_found;
    logic [SEL_W-1:0]     pick_sel;
    logic                 expired;
    logic                 slot_end;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
        assign src_arr[g] = src_value_i[g*DATA_W +: DATA_W];
    end

    rr_next_sel #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req_i   (src_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .sel_o   (pick_sel)
    );

    // An invalid on-screen source ends its slot even under hold.
    assign expired  = !hold_i && (cnt_q == CNT_W'(DWELL_CYCLES - 1));
    assign slot_end = expired || step_i || !src_valid_i[ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            ptr_q        <= SEL_W'(NUM_SRC - 1);
            cnt_q        <= '0;
            disp_value_q <= '0;
            disp_src_q   <= '0;
            disp_valid_q <= 1'b0;
            slot_start_q <= 1'b0;
            src_ack_q    <= '0;
        end else begin
            slot_start_q <= 1'b0;
            src_ack_q    <= '0;
            case (state_q)
                IDLE: begin
                    disp_valid_q <= 1'b0;
                    if (|src_valid_i) begin
                        state_q <= LATCH;
                    end
                end
                LATCH: begin
                    cnt_q <= '0;
                    if (pick_found) begin
                        disp_value_q <= src_arr[pick_sel];
                        disp_src_q   <= pick_sel;
                        ptr_q        <= pick_sel;
                        disp_valid_q <= 1'b1;
                        slot_start_q <= 1'b1;
                        src_ack_q    <= NUM_SRC'(onehot(32'(pick_sel)));
                        state_q      <= SHOW;
                    end else begin
                        disp_valid_q <= 1'b0;
                        state_q      <= IDLE;
                    end
                end
                SHOW: begin
                    if (slot_end) begin
                        state_q <= LATCH;
                    end else if (!hold_i) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign disp_value_o = disp_value_q;
    assign disp_src_o   = disp_src_q;
    assign disp_valid_o = disp_valid_q;
    assign slot_start_o = slot_start_q;
    assign src_ack_o    = src_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_display_source_scheduler.sv
`default_nettype none
// ============================================================================
//  tb_display_source_scheduler
//  Directed bench with a slot-level reference model and literal pins.
//  Revision: 1.0
// ============================================================================
module tb_display_source_scheduler;

    localparam int NUM_SRC = 4;
    localparam int DATA_W  = 16;
    localparam int DWELL   = 4;

    logic        clk;
    logic        rst_n;
    logic [63:0] src_value;
    logic [3:0]  src_valid;
    logic        hold;
    logic        step;
    logic [15:0] disp_value;
    logic [1:0]  disp_src;
    logic        disp_valid;
    logic        slot_start;
    logic [3:0]  src_ack;

    display_source_scheduler #(
        .NUM_SRC      (NUM_SRC),
        .DATA_W       (DATA_W),
        .DWELL_CYCLES (DWELL)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .src_value_i  (src_value),
        .src_valid_i  (src_valid),
        .hold_i       (hold),
        .step_i       (step),
        .disp_value_o (disp_value),
        .disp_src_o   (disp_src),
        .disp_valid_o (disp_valid),
        .slot_start_o (slot_start),
        .src_ack_o    (src_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int q_src[$];
    int q_ack[$];
    int q_val[$];
    int q_cyc[$];

    // Reference model: a slot is either being shown, about to be chosen, or absent.
    logic [15:0] e_val;
    int          e_src;
    bit          e_valid;
    bit          e_start;
    int          e_ack;
    bit          m_choose;
    bit          m_showing;
    int          m_last;
    int          m_shown_for;

    function automatic int next_requester(input int last, input logic [3:0] v);
        for (int k = 1; k <= NUM_SRC; k++) begin
            if (v[(last + k) % NUM_SRC]) return (last + k) % NUM_SRC;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int p;
        if (!rst_n) begin
            e_val = 16'h0; e_src = 0; e_valid = 0; e_start = 0; e_ack = 0;
            m_choose = 0; m_showing = 0; m_last = NUM_SRC - 1; m_shown_for = 0;
        end else begin
            e_start = 0;
            e_ack   = 0;
            if (m_choose) begin
                m_choose = 0;
                p = next_requester(m_last, src_valid);
                if (p >= 0) begin
                    e_val = src_value[p*16 +: 16];
                    e_src = p; m_last = p; e_valid = 1; e_start = 1;
                    e_ack = 1 << p; m_showing = 1; m_shown_for = 0;
                end else begin
                    e_valid = 0;
                end
            end else if (m_showing) begin
                if (step || !src_valid[m_last] || (!hold && m_shown_for == DWELL - 1)) begin
                    m_showing = 0;
                    m_choose  = 1;
                end else if (!hold) begin
                    m_shown_for++;
                end
            end else begin
                e_valid = 0;
                if (src_valid != 4'b0) m_choose = 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (rst_n) begin
            check("disp_value", 32'(disp_value), 32'(e_val));
            check("disp_src",   32'(disp_src),   32'(e_src));
            check("disp_valid", 32'(disp_valid), 32'(e_valid));
            check("slot_start", 32'(slot_start), 32'(e_start));
            check("src_ack",    32'(src_ack),    32'(e_ack));
            if (slot_start) begin
                q_src.push_back(int'(disp_src));
                q_ack.push_back(int'(src_ack));
                q_val.push_back(int'(disp_value));
                q_cyc.push_back(cyc);
            end
        end
        #1;
    endtask

    task automatic clear_q();
        q_src.delete(); q_ack.delete(); q_val.delete(); q_cyc.delete();
    endtask

    task automatic wait_start(input string name, input int budget);
        int n0;
        n0 = q_src.size();
        for (int i = 0; i < budget && q_src.size() == n0; i++) tick();
        if (q_src.size() == n0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int acc;
        int rot_src[5] = '{0, 1, 2, 3, 0};
        int rot_ack[5] = '{1, 2, 4, 8, 1};
        int rot_val[5] = '{'h1111, 'h2222, 'h3333, 'h4444, 'h1111};
        int skp_src[4] = '{1, 3, 1, 3};

        rst_n = 0; src_valid = 4'b0; hold = 0; step = 0;
        src_value = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        repeat (3) @(negedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 10; i++) tick();
        check("idle_valid",    32'(disp_valid), 32'd0);
        check("idle_value",    32'(disp_value), 32'd0);
        check("idle_no_start", 32'(q_src.size()), 32'd0);

        c0 = cyc;
        src_valid = 4'hF;
        repeat (5) wait_start("rot", 12);
        check("rot_first_latency", 32'(q_cyc[0] - c0), 32'd2);
        for (int i = 0; i < 5; i++) begin
            check("rot_src", 32'(q_src[i]), 32'(rot_src[i]));
            check("rot_ack", 32'(q_ack[i]), 32'(rot_ack[i]));
            check("rot_val", 32'(q_val[i]), 32'(rot_val[i]));
        end
        for (int i = 1; i < 5; i++) check("rot_spacing", 32'(q_cyc[i] - q_cyc[i-1]), 32'd5);

        clear_q();
        src_valid = 4'b1010;
        repeat (4) wait_start("skip", 12);
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            check("skip_src", 32'(q_src[i]), 32'(skp_src[i]));
            acc = acc | q_ack[i];
        end
        check("skip_no_ack_0_2", 32'(acc & 5), 32'd0);

        clear_q();
        wait_start("hold_src1", 12);
        check("hold_start_src", 32'(q_src[0]), 32'd1);
        hold = 1;
        clear_q();
        for (int i = 0; i < 20; i++) tick();
        check("hold_src",      32'(disp_src), 32'd1);
        check("hold_no_start", 32'(q_src.size()), 32'd0);
        c0 = cyc;
        step = 1;
        tick();
        step = 0;
        wait_start("step", 5);
        check("step_latency", 32'(q_cyc[0] - c0), 32'd2);
        check("step_src",     32'(q_src[0]), 32'd3);
        hold = 0;

        src_valid = 4'hF;
        clear_q();
        for (int i = 0; i < 4 && !(q_src.size() > 0 && q_src[$] == 2); i++)
            wait_start("drop_find", 12);
        check("drop_src2_shown", 32'(disp_src), 32'd2);
        tick();
        c0 = cyc;
        src_valid = 4'b1011;
        clear_q();
        wait_start("drop", 5);
        check("drop_latency", 32'(q_cyc[0] - c0), 32'd2);
        check("drop_src",     32'(q_src[0]), 32'd3);
        src_valid = 4'b0;
        repeat (4) tick();
        check("drop_idle_valid", 32'(disp_valid), 32'd0);
        check("drop_idle_value", 32'(disp_value), 32'h4444);

        src_value[15:0] = 16'h00AB;
        src_valid = 4'b0001;
        clear_q();
        wait_start("single1", 6);
        check("single_val1", 32'(q_val[0]), 32'h00AB);
        check("single_ack1", 32'(q_ack[0]), 32'd1);
        tick(); tick();
        src_value[15:0] = 16'h00CD;
        tick();
        check("single_frozen", 32'(disp_value), 32'h00AB);
        wait_start("single2", 8);
        check("single_val2",    32'(q_val[1]), 32'h00CD);
        check("single_ack2",    32'(q_ack[1]), 32'd1);
        check("single_spacing", 32'(q_cyc[1] - q_cyc[0]), 32'd5);

        tick();
        rst_n = 0;
        #1;
        check("rst_value", 32'(disp_value), 32'd0);
        check("rst_src",   32'(disp_src),   32'd0);
        check("rst_valid", 32'(disp_valid), 32'd0);
        check("rst_start", 32'(slot_start), 32'd0);
        check("rst_ack",   32'(src_ack),    32'd0);
        tick(); tick();
        rst_n = 1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Time-shares the 4-digit seven-segment display and LED bank between several requesters, e.g. ALU result, store data and PC.
- Round-robin over valid sources. Each selected value is latched and shown for a fixed dwell period.
- Drives the value consumed by seven_segment_display_subsystem and LED, and reports which source is on screen.
- Sits in top, between the processor's observation buses and the display subsystem.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DATA_W, 16, width of each displayed value (4 hex digits).
- DWELL_CYCLES, 100_000_000, clk cycles each source is shown (1 s at 100 MHz); must be >= 2.
- SEL_W, $clog2(NUM_SRC), source index width (derived, not overridden).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- src_value  in  NUM_SRC*DATA_W  packed source values; source i at [i*DATA_W +: DATA_W].
- src_valid  in  NUM_SRC  source i requests display time.
- hold  in  1  freeze: dwell counter stops and the current slot never expires.
- step  in  1  single-cycle pulse; ends the current slot immediately.
- disp_value  out  DATA_W  latched value for display/LED.
- disp_src  out  SEL_W  index of the source being shown.
- disp_valid  out  1  disp_value is meaningful.
- slot_start  out  1  one-cycle pulse when a new value is latched.
- src_ack  out  NUM_SRC  one-hot one-cycle pulse to the source just latched.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, ptr=NUM_SRC-1, dwell counter=0.
  - disp_value=0, disp_src=0, disp_valid=0, slot_start=0, src_ack=0.
  - Asserting reset mid-slot aborts the slot; no ack is issued.
  - After reset deasserts, the first search starts at source 0.
- All outputs are registered.
- FSM states:
  - IDLE: disp_valid=0; disp_value holds its last value (0 after reset). If |src_valid is sampled at an edge -> LATCH.
  - LATCH (one cycle): pick = first i with src_valid[i]=1, searching (ptr+1) mod NUM_SRC upward with wrap-around.
    - If a pick exists, at the next edge: disp_value<=src_value[pick], disp_src<=pick, ptr<=pick, disp_valid<=1, slot_start<=1, src_ack<=onehot(pick), counter<=0 -> SHOW.
    - If no source is valid in LATCH (valid dropped meanwhile) -> IDLE; outputs unchanged except disp_valid<=0.
  - SHOW:
    - Counter increments each cycle unless hold=1.
    - Expiry when counter==DWELL_CYCLES-1 and hold=0.
    - Expiry, step=1, or src_valid[ptr]=0 -> LATCH. step overrides hold.
    - Otherwise stay; disp_value is frozen (not live-tracking).
- Latency: src_valid rises before edge k (state IDLE) -> LATCH after edge k -> outputs updated and pulses high after edge k+1. Pulses last exactly one cycle.
- Slot length: with no hold/step, consecutive slot_start pulses are DWELL_CYCLES+1 cycles apart (dwell plus the LATCH cycle).
- Single valid source: it re-latches itself each slot, refreshing its value, and gets an ack each time.
- Simultaneous events:
  - step and expiry in the same cycle: one advance only.
  - src_valid[ptr] dropping while hold=1: still advances, since an invalid source is never shown.
- Round-robin fairness: a continuously valid source waits at most NUM_SRC-1 slots.
- Counter width is $clog2(DWELL_CYCLES). No wrap: the counter is cleared on every LATCH exit.

Decomposition:
- Package display_sched_pkg:
  - typedef enum logic [1:0] {IDLE, LATCH, SHOW} sched_state_t;
  - function onehot(sel) returning NUM_SRC-wide one-hot.
- Sub-module rr_next_sel: combinational round-robin picker.
  - Inputs: req[NUM_SRC], ptr[SEL_W].
  - Outputs: found, sel[SEL_W].
  - Unit-tested standalone.

Test Plan (bench uses NUM_SRC=4, DATA_W=16, DWELL_CYCLES=4):
- Reset/startup: reset low with src_valid=4'b0000, then release, idle 10 cycles -> disp_valid=0, disp_value=0, no pulses. Drive reset low mid-SHOW -> all outputs 0 immediately, before the next clk edge.
- Basic rotation: all valid, values 0x1111/0x2222/0x3333/0x4444 -> disp_src sequence 0,1,2,3,0. slot_start pulses 5 cycles apart. src_ack = 0001,0010,0100,1000. First latch appears 2 cycles after src_valid rises.
- Skip and wrap: src_valid=4'b1010 -> disp_src alternates 1,3,1,3. Sources 0 and 2 are never acked.
- Hold and step: assert hold during source 1's slot for 20 cycles -> disp_src stays 1, no slot_start. Pulse step while hold=1 -> source 3 is latched 2 cycles later.
- Valid drop: source 2 on screen, deassert src_valid[2] at counter=1 -> LATCH next cycle, then source 3 shown. Deassert all valids -> IDLE with disp_valid=0 and disp_value unchanged.
- Single source refresh: only src_valid[0], src_value changes 0x00AB->0x00CD mid-slot -> disp_value stays 0x00AB until the next slot, then 0x00CD. src_ack=0001 every 5 cycles.
